jt51_wr_sched: RTL

Write scheduler sitting between a host, CPU model or command-dump player and the `jt51` register port. It buffers register writes as (address, data) pairs in a small FIFO. Each pair is replayed as the two-step YM2151 access: an address write with `a0=0`, then a data write with `a0=1`. Between pairs it polls the busy flag on `dout[7]`, and it paces all bus activity to the FM clock enable so requesters never handle chip timing.

---
 rtl/jt51_wrsched_pkg.sv | 29 ++
 rtl/jt51_wrsched_fifo.sv | 55 +++++
 rtl/jt51_wr_sched.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/jt51_wrsched_pkg.sv
// ---------------------------------------------------------------------------
// jt51_wrsched_pkg : shared state encoding and constants for jt51_wr_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jt51_wrsched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AWR    = 3'd1,
    ST_AGAP   = 3'd2,
    ST_DWR    = 3'd3,
    ST_SETTLE = 3'd4,
    ST_POLL   = 3'd5
  } wrsched_state_e;

  localparam int BUSY_BIT = 7;
  localparam int ENTRY_W  = 16;

  // FIFO entries hold the register address in the upper byte.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [7:0] addr,
                                                    input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt51_wrsched_fifo.sv
// ---------------------------------------------------------------------------
// jt51_wrsched_fifo : DEPTH-entry synchronous FIFO with registered pointers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jt51_wrsched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/jt51_wr_sched.sv
// ---------------------------------------------------------------------------
// jt51_wr_sched : buffers (addr,data) writes and replays them to jt51 paced
// by cen and the busy flag. Option: JT51_WRSCHED_TIMEOUT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jt51_wr_sched
  import jt51_wrsched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       a0,
  output logic       wr_n,
  output logic [7:0] din,
  input  logic [7:0] dout,
  output logic       idle,
  output logic       err
);

  localparam int            SW         = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LD  = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_ONE = SW'(1);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;
  logic                 fifo_pop;
  logic                 busy;
  logic                 idle_go;
  logic                 poll_done;
  logic                 unused_dout;
  wrsched_state_e       state_q;
  logic [SW-1:0]        settle_q;
  logic [SW-1:0]        settle_d;
  logic                 a0_q;
  logic                 wr_n_q;
  logic [7:0]           din_q;

  jt51_wrsched_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid),
    .wdata_i (pack_entry(req_addr, req_data)),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign busy        = dout[BUSY_BIT];
  assign unused_dout = ^dout[BUSY_BIT-1:0];
  assign fifo_pop    = cen && (state_q == ST_DWR);
  assign settle_d    = (settle_q == '0) ? '0 : settle_q - SETTLE_ONE;

`ifdef JT51_WRSCHED_TIMEOUT_EN
  localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic [TW-1:0] tmo_q;
  logic          tmo_hit;
  logic          err_q;

  // A stuck busy flag is abandoned after TIMEOUT cen pulses of waiting.
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign idle_go   = !fifo_empty && (!busy || tmo_hit);
  assign poll_done = !busy || tmo_hit;
  assign err       = err_q;
`else
  localparam int unused_timeout = TIMEOUT;

  assign idle_go   = !fifo_empty && !busy;
  assign poll_done = !busy;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      a0_q     <= 1'b0;
      din_q    <= 8'h00;
      wr_n_q   <= 1'b1;
`ifdef JT51_WRSCHED_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else if (cen) begin
      case (state_q)
        ST_IDLE: begin
          if (idle_go) begin
            a0_q    <= 1'b0;
            din_q   <= fifo_head[15:8];
            wr_n_q  <= 1'b0;
            state_q <= ST_AWR;
          end
`ifdef JT51_WRSCHED_TIMEOUT_EN
          if (idle_go || fifo_empty) tmo_q <= '0;
          else                       tmo_q <= tmo_q + TMO_ONE;
          if (!fifo_empty && busy && tmo_hit) err_q <= 1'b1;
`endif
        end
        ST_AWR: begin
          wr_n_q  <= 1'b1;
          state_q <= ST_AGAP;
        end
        ST_AGAP: begin
          a0_q    <= 1'b1;
          din_q   <= fifo_head[7:0];
          wr_n_q  <= 1'b0;
          state_q <= ST_DWR;
        end
        ST_DWR: begin
          wr_n_q   <= 1'b1;
          settle_q <= SETTLE_LD;
          state_q  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          settle_q <= settle_d;
          if (settle_q <= SETTLE_ONE) state_q <= ST_POLL;
`ifdef JT51_WRSCHED_TIMEOUT_EN
          tmo_q <= '0;
`endif
        end
        ST_POLL: begin
          if (poll_done) state_q <= ST_IDLE;
`ifdef JT51_WRSCHED_TIMEOUT_EN
          tmo_q <= poll_done ? '0 : tmo_q + TMO_ONE;
          if (busy && tmo_hit) err_q <= 1'b1;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a0        = a0_q;
  assign wr_n      = wr_n_q;
  assign din       = din_q;
  assign req_ready = !fifo_full;
  assign idle      = fifo_empty && (state_q == ST_IDLE) && !busy;

endmodule

`default_nettype wire
